nes_video_gen: RTL and testbench

//  NES raster generator feeding video_mixer: counts dots/lines on pix_ce, converts the PPU 6-bit

---
 rtl/nes_video_gen.sv | 169 ++++++++++++++++
 tb/tb_nes_video_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/nes_video_gen.sv
// NES raster generator: dot/line counters on pix_ce, 6-bit palette to 24-bit RGB, syncs and blanking.
// Optional emphasis attenuation is enabled by defining NES_VIDEO_EMPHASIS_EN.
module nes_video_gen (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic       frame_sync,
    input  logic [5:0] color,
    input  logic [2:0] emphasis,
    input  logic       hide_overscan,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       HSync,
    output logic       VSync,
    output logic       HBlank,
    output logic       VBlank,
    output logic [8:0] hcount,
    output logic [8:0] vcount
);

    localparam logic [8:0] H_TOTAL   = 9'd341;
    localparam logic [8:0] H_ACTIVE  = 9'd256;
    localparam logic [8:0] HS_START  = 9'd277;
    localparam logic [8:0] HS_WIDTH  = 9'd25;
    localparam logic [8:0] V_TOTAL   = 9'd262;
    localparam logic [8:0] V_ACTIVE  = 9'd240;
    localparam logic [8:0] VS_START  = 9'd244;
    localparam logic [8:0] VS_WIDTH  = 9'd3;
    localparam logic [8:0] OVS_LINES = 9'd8;

    logic [8:0]  hcount_q, hcount_d;
    logic [8:0]  vcount_q, vcount_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        hblank_q, hblank_d, vblank_q, vblank_d;

    logic [23:0] pal_rgb;
    logic [7:0]  r_emph, g_emph, b_emph;
    logic        hb_now, vb_now, ovs_now, mask_now;

    always_comb begin
        pal_rgb = 24'h000000;
        case (color)
            6'h00: pal_rgb = 24'h666666;  6'h01: pal_rgb = 24'h002A88;
            6'h02: pal_rgb = 24'h1412A7;  6'h03: pal_rgb = 24'h3B00A4;
            6'h04: pal_rgb = 24'h5C007E;  6'h05: pal_rgb = 24'h6E0040;
            6'h06: pal_rgb = 24'h6C0600;  6'h07: pal_rgb = 24'h561D00;
            6'h08: pal_rgb = 24'h333500;  6'h09: pal_rgb = 24'h0B4800;
            6'h0A: pal_rgb = 24'h005200;  6'h0B: pal_rgb = 24'h004F08;
            6'h0C: pal_rgb = 24'h00404D;  6'h0D: pal_rgb = 24'h000000;
            6'h0E: pal_rgb = 24'h000000;  6'h0F: pal_rgb = 24'h000000;
            6'h10: pal_rgb = 24'hADADAD;  6'h11: pal_rgb = 24'h155FD9;
            6'h12: pal_rgb = 24'h4240FF;  6'h13: pal_rgb = 24'h7527FE;
            6'h14: pal_rgb = 24'hA01ACC;  6'h15: pal_rgb = 24'hB71E7B;
            6'h16: pal_rgb = 24'hB53120;  6'h17: pal_rgb = 24'h994E00;
            6'h18: pal_rgb = 24'h6B6D00;  6'h19: pal_rgb = 24'h388700;
            6'h1A: pal_rgb = 24'h0C9300;  6'h1B: pal_rgb = 24'h008F32;
            6'h1C: pal_rgb = 24'h007C8D;  6'h1D: pal_rgb = 24'h000000;
            6'h1E: pal_rgb = 24'h000000;  6'h1F: pal_rgb = 24'h000000;
            6'h20: pal_rgb = 24'hFFFEFF;  6'h21: pal_rgb = 24'h64B0FF;
            6'h22: pal_rgb = 24'h9290FF;  6'h23: pal_rgb = 24'hC676FF;
            6'h24: pal_rgb = 24'hF36AFF;  6'h25: pal_rgb = 24'hFE6ECC;
            6'h26: pal_rgb = 24'hFE8170;  6'h27: pal_rgb = 24'hEA9E22;
            6'h28: pal_rgb = 24'hBCBE00;  6'h29: pal_rgb = 24'h88D800;
            6'h2A: pal_rgb = 24'h5CE430;  6'h2B: pal_rgb = 24'h45E082;
            6'h2C: pal_rgb = 24'h48CDDE;  6'h2D: pal_rgb = 24'h4F4F4F;
            6'h2E: pal_rgb = 24'h000000;  6'h2F: pal_rgb = 24'h000000;
            6'h30: pal_rgb = 24'hFFFEFF;  6'h31: pal_rgb = 24'hC0DFFF;
            6'h32: pal_rgb = 24'hD3D2FF;  6'h33: pal_rgb = 24'hE8C8FF;
            6'h34: pal_rgb = 24'hFBC2FF;  6'h35: pal_rgb = 24'hFEC4EA;
            6'h36: pal_rgb = 24'hFECCC5;  6'h37: pal_rgb = 24'hF7D8A5;
            6'h38: pal_rgb = 24'hE4E594;  6'h39: pal_rgb = 24'hCFEF96;
            6'h3A: pal_rgb = 24'hBDF4AB;  6'h3B: pal_rgb = 24'hB3F3CC;
            6'h3C: pal_rgb = 24'hB5EBF2;  6'h3D: pal_rgb = 24'hB8B8B8;
            6'h3E: pal_rgb = 24'h000000;  6'h3F: pal_rgb = 24'h000000;
            default: pal_rgb = 24'h000000;
        endcase
    end

`ifdef NES_VIDEO_EMPHASIS_EN
    // A channel dims when any emphasis bit other than its own is set.
    always_comb begin
        r_emph = pal_rgb[23:16];
        g_emph = pal_rgb[15:8];
        b_emph = pal_rgb[7:0];
        if (|(emphasis & 3'b110)) r_emph = pal_rgb[23:16] - (pal_rgb[23:16] >> 2);
        if (|(emphasis & 3'b101)) g_emph = pal_rgb[15:8]  - (pal_rgb[15:8]  >> 2);
        if (|(emphasis & 3'b011)) b_emph = pal_rgb[7:0]   - (pal_rgb[7:0]   >> 2);
    end
`else
    logic emphasis_unused;
    assign emphasis_unused = ^emphasis;
    assign r_emph = pal_rgb[23:16];
    assign g_emph = pal_rgb[15:8];
    assign b_emph = pal_rgb[7:0];
`endif

    assign hb_now   = hcount_q >= H_ACTIVE;
    assign vb_now   = vcount_q >= V_ACTIVE;
    assign ovs_now  = hide_overscan & ((vcount_q < OVS_LINES) | (vcount_q >= V_ACTIVE - OVS_LINES));
    assign mask_now = hb_now | vb_now | ovs_now;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        if (pix_ce) begin
            r_d      = mask_now ? 8'h00 : r_emph;
            g_d      = mask_now ? 8'h00 : g_emph;
            b_d      = mask_now ? 8'h00 : b_emph;
            hsync_d  = (hcount_q >= HS_START) && (hcount_q < HS_START + HS_WIDTH);
            vsync_d  = (vcount_q >= VS_START) && (vcount_q < VS_START + VS_WIDTH);
            hblank_d = hb_now;
            vblank_d = vb_now;
            // frame_sync takes priority over the normal wrap/increment
            if (frame_sync) begin
                hcount_d = 9'd0;
                vcount_d = 9'd0;
            end else if (hcount_q == H_TOTAL - 9'd1) begin
                hcount_d = 9'd0;
                vcount_d = (vcount_q == V_TOTAL - 9'd1) ? 9'd0 : vcount_q + 9'd1;
            end else begin
                hcount_d = hcount_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hcount_q <= 9'd0;
            vcount_q <= 9'd0;
            r_q      <= 8'h00;
            g_q      <= 8'h00;
            b_q      <= 8'h00;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
        end
    end

    assign R      = r_q;
    assign G      = g_q;
    assign B      = b_q;
    assign HSync  = hsync_q;
    assign VSync  = vsync_q;
    assign HBlank = hblank_q;
    assign VBlank = vblank_q;
    assign hcount = hcount_q;
    assign vcount = vcount_q;

endmodule

// File: tb/tb_nes_video_gen.sv
// Scoreboard bench for nes_video_gen: random stimulus, expected outputs from a raster-level model.
module tb_nes_video_gen;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic       frame_sync = 1'b0;
    logic [5:0] color = 6'h00;
    logic [2:0] emphasis = 3'b000;
    logic       hide_overscan = 1'b0;
    logic [7:0] R, G, B;
    logic       HSync, VSync, HBlank, VBlank;
    logic [8:0] hcount, vcount;

    nes_video_gen dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .pix_ce(pix_ce), .frame_sync(frame_sync),
        .color(color), .emphasis(emphasis), .hide_overscan(hide_overscan),
        .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .hcount(hcount), .vcount(vcount)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs, hb, vb;
        logic [8:0] h, v;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp = '0;
    int   mh = 0, mv = 0;
    int   n_pass = 0, n_total = 0;
    logic [5:0] anchors [13] = '{6'h0D, 6'h0E, 6'h0F, 6'h1D, 6'h1E, 6'h1F,
                                 6'h2E, 6'h2F, 6'h3E, 6'h3F, 6'h20, 6'h30, 6'h00};

    function automatic logic [23:0] ref_pal(input logic [5:0] c);
        if (c == 6'h00) return 24'h666666;
        if (c == 6'h20 || c == 6'h30) return 24'hFFFEFF;
        return 24'h000000;
    endfunction

    function automatic logic [7:0] ref_chan(input logic [7:0] x, input logic [2:0] em, input int c);
        logic [7:0] y;
        y = x;
`ifdef NES_VIDEO_EMPHASIS_EN
        if ((em & ~(3'b001 << c)) != 3'b000) y = x - (x / 8'd4);
`else
        if (em == 3'b111 && c > 2) y = 8'h00;
`endif
        return y;
    endfunction

    function automatic exp_t dot_model(input int h, input int v, input logic [5:0] col,
                                       input logic [2:0] em, input logic hide);
        exp_t e;
        logic [23:0] rgb;
        logic blank;
        e = '0;
        rgb = ref_pal(col);
        e.hb = (h >= 256);
        e.vb = (v >= 240);
        e.hs = (h >= 277) && (h <= 301);
        e.vs = (v >= 244) && (v <= 246);
        blank = e.hb || e.vb || (hide && (v < 8 || v >= 232));
        if (!blank) begin
            e.r = ref_chan(rgb[23:16], em, 0);
            e.g = ref_chan(rgb[15:8], em, 1);
            e.b = ref_chan(rgb[7:0], em, 2);
        end
        return e;
    endfunction

    task automatic step(input logic rst_n_i, input logic ce, input logic fs,
                        input logic [5:0] col, input logic [2:0] em, input logic hide);
        exp_t e;
        @(negedge clk_sys);
        reset_n = rst_n_i; pix_ce = ce; frame_sync = fs;
        color = col; emphasis = em; hide_overscan = hide;
        e = last_exp;
        if (!rst_n_i) begin
            e = '0; mh = 0; mv = 0;
        end else if (ce) begin
            e = dot_model(mh, mv, col, em, hide);
            if (fs) begin
                mh = 0; mv = 0;
            end else begin
                mh = mh + 1;
                if (mh == 341) begin
                    mh = 0;
                    mv = (mv == 261) ? 0 : mv + 1;
                end
            end
            e.h = 9'(mh);
            e.v = 9'(mv);
        end
        last_exp = e;
        exp_q.push_back(e);
    endtask

    // Monitor: every clock edge presents a settled output bundle to compare.
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{r: R, g: G, b: B, hs: HSync, vs: VSync, hb: HBlank, vb: VBlank,
                        h: hcount, v: vcount};
                n_total++;
                if (got === e) n_pass++;
                else $display("FAIL dot_bundle got r%h g%h b%h hs%b vs%b hb%b vb%b h%0d v%0d required r%h g%h b%h hs%b vs%b hb%b vb%b h%0d v%0d",
                              got.r, got.g, got.b, got.hs, got.vs, got.hb, got.vb, got.h, got.v,
                              e.r, e.g, e.b, e.hs, e.vs, e.hb, e.vb, e.h, e.v);
            end
        end
    end

    initial begin
        int ce_cnt;
        logic ce, fs;
        // Reset with pix_ce toggling and frame_sync noise
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)), anchors[$urandom_range(0, 12)],
                 3'($urandom), 1'($urandom));
        // Full frame plus a little, with sparse pix_ce gaps; frame_sync on the very last dot
        ce_cnt = 0;
        while (ce_cnt < 341 * 262 + 40) begin
            ce = ($urandom_range(0, 127) != 0);
            fs = ce && (mh == 340) && (mv == 261) && (ce_cnt < 341 * 262);
            step(1'b1, ce, fs, anchors[$urandom_range(0, 12)], 3'($urandom), 1'($urandom));
            if (ce) ce_cnt++;
        end
        // Colour 0x30 with emphasis on R only, free-running
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 1'b0, 6'h30, 3'b001, 1'b0);
        // pix_ce every 4th clock with random frame_sync
        for (int i = 0; i < 2000; i++) begin
            ce = (i % 4 == 3);
            fs = ce && ($urandom_range(0, 149) == 0);
            step(1'b1, ce, fs, anchors[$urandom_range(0, 12)], 3'($urandom), 1'($urandom));
        end
        // Mid-frame reset coinciding with frame_sync and pix_ce
        step(1'b0, 1'b1, 1'b1, 6'h30, 3'b000, 1'b0);
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, anchors[$urandom_range(0, 12)],
                 3'($urandom), 1'($urandom));
        repeat (3) @(posedge clk_sys);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL queue_drain got %0d left required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
